// File: rtl/readout_seq.sv
// readout_seq: reads a window of captured samples from a synchronous RAM,
// newest first, and hands them one at a time to a UART transmitter.
// Optional XON/XOFF flow control is built when READOUT_SEQ_XONOFF_EN is defined.
module readout_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 5
) (
    input  logic             clk_i,
    input  logic             rst_in,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [DEPTH-1:0] wr_ptr_i,
    input  logic [DEPTH:0]   count_i,
    input  logic [WIDTH-1:0] mem_q_i,
    output logic [DEPTH-1:0] mem_addr_o,
    output logic             mem_en_o,
    input  logic             tx_rdy_i,
    output logic             tx_stb_o,
    output logic [31:0]      tx_data_o,
    input  logic             xon_i,
    input  logic             xoff_i,
    output logic             busy_o,
    output logic             done_o
);

    localparam int unsigned CNT_W = DEPTH + 1;
    localparam int unsigned CAP   = 1 << DEPTH;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        READ = 3'd2,
        SEND = 3'd3,
        GAP  = 3'd4,
        FIN  = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [DEPTH-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic [31:0]        tx_data_q, tx_data_d;
    logic [CNT_W-1:0]   count_clamped;
    logic               tx_stb_c;
    logic               mem_en_q, busy_q, done_q;
    logic               paused_q;

`ifdef READOUT_SEQ_XONOFF_EN
    logic paused_d;

    // Pause flag: xon wins over xoff; start and abort always resume.
    always_comb begin
        paused_d = paused_q;
        if (xoff_i) paused_d = 1'b1;
        if (xon_i)  paused_d = 1'b0;
        if (abort_i || (state_q == IDLE && start_i)) paused_d = 1'b0;
    end

    // Pause flag register.
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) paused_q <= 1'b0;
        else         paused_q <= paused_d;
    end
`else
    logic unused_flow_ctrl;

    // Flow control absent: host pulses have no effect.
    assign paused_q         = 1'b0;
    assign unused_flow_ctrl = &{1'b0, xon_i, xoff_i};
`endif

    // Requested sample count saturated at the RAM capacity.
    assign count_clamped = (count_i > CNT_W'(CAP)) ? CNT_W'(CAP) : count_i;

    // Next-state and datapath update; abort overrides every transition.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        tx_data_d   = tx_data_q;
        tx_stb_c    = 1'b0;
        if (state_q != IDLE && abort_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        addr_d      = wr_ptr_i;
                        remaining_d = count_clamped;
                        state_d     = (count_clamped == '0) ? FIN : ADDR;
                    end
                end
                ADDR: state_d = READ;
                READ: begin
                    tx_data_d = 32'(mem_q_i);
                    state_d   = SEND;
                end
                SEND: begin
                    if (tx_rdy_i && !paused_q) begin
                        tx_stb_c = 1'b1;
                        state_d  = GAP;
                    end
                end
                GAP: begin
                    remaining_d = remaining_q - CNT_W'(1);
                    addr_d      = addr_q - DEPTH'(1);
                    state_d     = (remaining_q == CNT_W'(1)) ? FIN : ADDR;
                end
                FIN:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Datapath registers and state-decoded outputs, aligned with the state they describe.
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            addr_q      <= '0;
            remaining_q <= '0;
            tx_data_q   <= '0;
            mem_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            tx_data_q   <= tx_data_d;
            mem_en_q    <= (state_d == ADDR);
            busy_q      <= (state_d != IDLE);
            done_q      <= (state_d == FIN);
        end
    end

    // Strobe follows tx_rdy_i in the same cycle so it can never fire while the UART is busy.
    assign tx_stb_o   = tx_stb_c;
    assign tx_data_o  = tx_data_q;
    assign mem_addr_o = addr_q;
    assign mem_en_o   = mem_en_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;

endmodule

// File: tb/tb_readout_seq.sv
// Bench for readout_seq (WIDTH=8, DEPTH=5): directed scenarios plus randomized
// readouts, with expected sample streams computed from a RAM image in the bench.
module tb_readout_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic        abort_i = 1'b0;
    logic [4:0]  wr_ptr_i = '0;
    logic [5:0]  count_i = '0;
    logic [7:0]  mem_q = '0;
    logic [4:0]  mem_addr_o;
    logic        mem_en_o;
    logic        tx_rdy_i = 1'b0;
    logic        tx_stb_o;
    logic [31:0] tx_data_o;
    logic        xon_i = 1'b0;
    logic        xoff_i = 1'b0;
    logic        busy_o;
    logic        done_o;

    int          n_assert = 0;
    int          n_fail = 0;
    int          cyc_n = 0;
    int          n_done = 0;
    int          n_en = 0;
    logic [7:0]  ram [32];
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    int          stb_cyc[$];

    readout_seq #(.WIDTH(8), .DEPTH(5)) dut (
        .clk_i(clk), .rst_in(rst_n), .start_i(start_i), .abort_i(abort_i),
        .wr_ptr_i(wr_ptr_i), .count_i(count_i), .mem_q_i(mem_q),
        .mem_addr_o(mem_addr_o), .mem_en_o(mem_en_o), .tx_rdy_i(tx_rdy_i),
        .tx_stb_o(tx_stb_o), .tx_data_o(tx_data_o), .xon_i(xon_i), .xoff_i(xoff_i),
        .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    // Synchronous RAM model: one-cycle read latency.
    always @(posedge clk) begin
        cyc_n <= cyc_n + 1;
        if (mem_en_o) mem_q <= ram[mem_addr_o];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Transaction monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_stb_o === 1'b1) begin
                got_q.push_back(tx_data_o);
                stb_cyc.push_back(cyc_n);
                check("stb_needs_rdy", 64'(tx_rdy_i), 64'd1);
            end
            if (done_o === 1'b1)   n_done++;
            if (mem_en_o === 1'b1) n_en++;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic start_readout(input int wr, input int cnt);
        int n;
        logic [4:0] a;
        exp_q.delete(); got_q.delete(); stb_cyc.delete();
        n_done = 0; n_en = 0;
        n = (cnt > 32) ? 32 : cnt;
        for (int k = 0; k < n; k++) begin
            a = 5'(wr - k);
            exp_q.push_back(32'(ram[a]));
        end
        cyc();
        start_i = 1'b1; wr_ptr_i = 5'(wr); count_i = 6'(cnt);
        cyc();
        start_i = 1'b0;
    endtask

    task automatic wait_idle(input bit rnd, output int cycles);
        bit fin;
        fin = 1'b0;
        cycles = 0;
        for (int i = 0; i < 3000 && !fin; i++) begin
            @(negedge clk);
            if (busy_o === 1'b0) begin
                fin = 1'b1;
                cycles = i;
            end else begin
                cyc();
                if (rnd) tx_rdy_i = ($urandom_range(0, 3) != 0);
            end
        end
        if (!fin) check("idle_timeout", 64'd0, 64'd1);
    endtask

    task automatic finish_check(input bit spacing, input int exp_done);
        check("n_strobes", 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("data[%0d]", i), 64'(got_q[i]), 64'(exp_q[i]));
        check("done_pulses", 64'(n_done), 64'(exp_done));
        if (exp_done == 1) check("mem_reads", 64'(n_en), 64'(exp_q.size()));
        if (spacing)
            for (int i = 1; i < stb_cyc.size(); i++)
                check("period", 64'(stb_cyc[i] - stb_cyc[i-1]), 64'd4);
    endtask

    task automatic wait_strobes(input int target);
        int i;
        for (i = 0; i < 500 && got_q.size() < target; i++) cyc();
        if (i == 500) check("strobe_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int cyc_cnt;
        int wr;
        int cnt;
        int n_mid;
        logic [31:0] held;

        for (int i = 0; i < 32; i++) ram[i] = 8'(i);

        // Reset state
        cyc(); cyc();
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_done", 64'(done_o), 64'd0);
        check("rst_stb", 64'(tx_stb_o), 64'd0);
        check("rst_mem_en", 64'(mem_en_o), 64'd0);
        check("rst_tx_data", 64'(tx_data_o), 64'd0);
        check("rst_mem_addr", 64'(mem_addr_o), 64'd0);
        rst_n = 1'b1;
        repeat (3) cyc();
        check("idle_after_rst", 64'(busy_o), 64'd0);

        // Directed example: newest first with wrap below address 0
        tx_rdy_i = 1'b1;
        start_readout(3, 5);
        wait_idle(1'b0, cyc_cnt);
        finish_check(1'b1, 1);
        check("ex_last", 64'(got_q.size() == 5 ? got_q[4] : 32'hDEAD), 64'h1F);

        // Zero count: done without any reads or strobes
        start_readout(7, 0);
        wait_idle(1'b0, cyc_cnt);
        finish_check(1'b0, 1);
        check("zero_cnt_quick", 64'(cyc_cnt <= 2), 64'd1);

        // Oversized count saturates at capacity
        start_readout(17, 40);
        wait_idle(1'b0, cyc_cnt);
        finish_check(1'b1, 1);

        // Start pulses while busy are ignored
        start_readout(10, 4);
        cyc(); start_i = 1'b1; wr_ptr_i = 5'd30; count_i = 6'd9;
        cyc(); cyc(); start_i = 1'b0;
        wait_idle(1'b0, cyc_cnt);
        finish_check(1'b1, 1);

        // Randomized readouts with random RAM contents and back-pressure
        for (int i = 0; i < 32; i++) ram[i] = 8'($urandom);
        for (int t = 0; t < 8; t++) begin
            wr  = int'($urandom_range(0, 31));
            cnt = int'($urandom_range(0, 63));
            tx_rdy_i = $urandom_range(0, 1) != 0;
            start_readout(wr, cnt);
            wait_idle(1'b1, cyc_cnt);
            finish_check(1'b0, 1);
        end

        // Long tx_rdy stall in SEND
        tx_rdy_i = 1'b0;
        start_readout(9, 2);
        repeat (22) cyc();
        @(negedge clk);
        check("stall_no_strobe", 64'(got_q.size()), 64'd0);
        check("stall_busy", 64'(busy_o), 64'd1);
        check("stall_data", 64'(tx_data_o), 64'(ram[9]));
        held = tx_data_o;
        cyc();
        tx_rdy_i = 1'b1;
        @(negedge clk);
        check("stb_on_rdy", 64'(tx_stb_o), 64'd1);
        check("data_held", 64'(tx_data_o), 64'(held));
        wait_idle(1'b0, cyc_cnt);
        finish_check(1'b0, 1);

        // XOFF after the 2nd strobe, XON 50 cycles later
        tx_rdy_i = 1'b1;
        start_readout(4, 6);
        wait_strobes(2);
        xoff_i = 1'b1;
        cyc();
        xoff_i = 1'b0;
        repeat (49) cyc();
        n_mid = got_q.size();
`ifdef READOUT_SEQ_XONOFF_EN
        check("paused_no_strobes", 64'(n_mid), 64'd2);
`else
        check("xoff_ignored", 64'(n_mid), 64'd6);
`endif
        xon_i = 1'b1;
        cyc();
        xon_i = 1'b0;
        wait_idle(1'b0, cyc_cnt);
`ifdef READOUT_SEQ_XONOFF_EN
        finish_check(1'b0, 1);
`else
        finish_check(1'b1, 1);
`endif

        // Abort during the 3rd sample's READ
        start_readout(20, 8);
        for (int i = 0; i < 200 && n_en < 3; i++) cyc();
        check("abort_reached_read", 64'(n_en), 64'd3);
        abort_i = 1'b1;
        cyc();
        abort_i = 1'b0;
        @(negedge clk);
        check("abort_busy_low", 64'(busy_o), 64'd0);
        repeat (15) cyc();
        check("abort_strobes", 64'(got_q.size()), 64'd2);
        check("abort_no_done", 64'(n_done), 64'd0);
        for (int i = 0; i < 2 && i < got_q.size(); i++)
            check($sformatf("abort_data[%0d]", i), 64'(got_q[i]), 64'(exp_q[i]));
        start_readout(2, 3);
        wait_idle(1'b0, cyc_cnt);
        finish_check(1'b1, 1);

        // Reset asserted during GAP
        start_readout(12, 6);
        wait_strobes(2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 64'(busy_o), 64'd0);
        check("mid_rst_stb", 64'(tx_stb_o), 64'd0);
        check("mid_rst_mem_en", 64'(mem_en_o), 64'd0);
        check("mid_rst_done", 64'(done_o), 64'd0);
        check("mid_rst_tx_data", 64'(tx_data_o), 64'd0);
        check("mid_rst_mem_addr", 64'(mem_addr_o), 64'd0);
        cyc(); cyc();
        rst_n = 1'b1;
        repeat (20) cyc();
        check("post_rst_idle", 64'(busy_o), 64'd0);
        check("post_rst_strobes", 64'(got_q.size()), 64'd2);
        check("post_rst_no_done", 64'(n_done), 64'd0);
        start_readout(0, 2);
        wait_idle(1'b0, cyc_cnt);
        finish_check(1'b1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/readout_seq.md
READOUT_SEQ -- requirements
Module: readout_seq

Interface
REQ-001 Parameter WIDTH, default 32: sample width in bits, 1..32.
REQ-002 Parameter DEPTH, default 5: RAM address bits; capacity 2**DEPTH samples.
REQ-003 clk_i  in  1  system clock; one clock domain, all logic rising-edge.
REQ-004 rst_in  in  1  asynchronous, active-low reset.
REQ-005 start_i  in  1  begin readout, sampled in IDLE only.
REQ-006 abort_i  in  1  cancel readout from any state.
REQ-007 wr_ptr_i  in  DEPTH  address of newest captured sample, latched at start.
REQ-008 count_i  in  DEPTH+1  number of samples to send, latched at start.
REQ-009 mem_q_i  in  WIDTH  RAM read data, valid one cycle after mem_addr_o/mem_en_o.
REQ-010 mem_addr_o  out  DEPTH  RAM read address.
REQ-011 mem_en_o  out  1  RAM read enable.
REQ-012 tx_rdy_i  in  1  UART transmitter idle.
REQ-013 tx_stb_o  out  1  one-cycle transmit strobe.
REQ-014 tx_data_o  out  32  sample zero-extended to 32 bits.
REQ-015 xon_i, xoff_i  in  1 each  host flow-control pulses.
REQ-016 busy_o  out  1  high outside IDLE.
REQ-017 done_o  out  1  one-cycle pulse on normal completion.

Function
REQ-018 FSM states SHALL be IDLE, ADDR, READ, SEND, GAP, FIN.
REQ-019 IDLE: start_i=1 latches wr_ptr_i into addr, min(count_i, 2**DEPTH) into remaining; -> FIN if latched count=0, else -> ADDR.
REQ-020 start_i outside IDLE SHALL be ignored.
REQ-021 ADDR: mem_en_o=1, mem_addr_o=addr for exactly one cycle; -> READ.
REQ-022 READ: register mem_q_i zero-extended into tx_data_o; -> SEND.
REQ-023 SEND: when tx_rdy_i=1 and not paused, tx_stb_o=1 for one cycle, tx_data_o stable; -> GAP; otherwise hold.
REQ-024 GAP: one unconditional cycle; decrement remaining, addr <= addr-1 modulo 2**DEPTH (0 wraps to 2**DEPTH-1); -> FIN if remaining was 1, else ADDR.
REQ-025 Samples SHALL be sent newest first: wr_ptr, wr_ptr-1, ... .
REQ-026 FIN: done_o=1 one cycle; -> IDLE.
REQ-027 abort_i=1 in any non-IDLE state SHALL force IDLE next cycle, no tx_stb_o, no done_o; abort has priority over all transitions.
REQ-028 tx_stb_o SHALL never assert while tx_rdy_i=0.
REQ-029 Minimum per-sample period with tx_rdy_i held high: 4 cycles (ADDR, READ, SEND, GAP).

Reset
REQ-030 rst_in=0 SHALL asynchronously force IDLE, paused=0, addr=0, remaining=0, tx_data_o=0, and mem_en_o, tx_stb_o, busy_o, done_o=0.
REQ-031 Reset mid-readout SHALL drop the transfer with no further strobes after release.

Configuration
REQ-032 Macro READOUT_SEQ_XONOFF_EN selects flow control.
REQ-033 Defined: xoff_i pulse sets paused, xon_i clears it; both same cycle -> paused cleared; paused stalls SEND only; paused cleared on start and abort.
REQ-034 Undefined: xon_i/xoff_i ignored, paused constant 0, no pause register synthesized.

Verification
REQ-035 WIDTH=8, DEPTH=5, RAM[i]=i, wr_ptr_i=3, count_i=5, tx_rdy_i=1 -> strobes with data 0x03,0x02,0x01,0x00,0x1F, then one done_o pulse.
REQ-036 count_i=0 -> done_o two cycles after start, zero strobes; count_i=40 -> exactly 32 strobes.
REQ-037 tx_rdy_i low 20 cycles during SEND -> tx_stb_o stays low, asserts in first cycle tx_rdy_i=1, tx_data_o unchanged.
REQ-038 XONOFF_EN defined: xoff_i after 2nd strobe, xon_i 50 cycles later -> no strobes in between, remaining samples delivered in order; undefined -> no gap.
REQ-039 abort_i during 3rd sample READ -> busy_o low next cycle, no further strobes, no done_o; new start_i accepted after.
REQ-040 rst_in low during GAP -> all outputs 0 immediately; after release, idle until start_i.
